common_credit_decr2: RTL and testbench
======================================

Name: common_credit_decr2

Overview:
- Credit consumer (transmit-side) counter for a 4-credit link.
- Each request accepted on the issue side consumes one credit via 2-bit decrement-with-borrow. Each credit-return pulse from the receiver restores one credit.
- Sits in front of any small 4-deep downstream buffer in the core.
- Gates issue when no credits remain, and flags protocol violations where more credits are returned than were issued.

Parameters:
- CREDIT_INIT, 4, credits loaded after reset. Legal range 1..4. Other values are a static configuration error.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req_valid  input  1  upstream has a transfer to issue.
- o_req_ready  output  1  a credit is available and the block is accepting.
- o_issue  output  1  combinational; i_req_valid & o_req_ready, so one credit is consumed this cycle.
- i_credit_return  input  1  single-cycle pulse from the receiver; one credit returned.
- o_credit_count  output  3  registered current credits, 0..4.
- o_starved  output  1  registered; o_credit_count == 0.
- o_full  output  1  registered; o_credit_count == CREDIT_INIT.
- o_err_overflow  output  1  registered, sticky; a return was received while the count was already full.

Behaviour:
- Reset: while reset=1 at a clock edge:
  - state <= INIT, count <= 0.
  - Outputs: o_req_ready=0, o_issue=0, o_starved=1, o_full=0, o_err_overflow=0.
  - Reset mid-operation discards all in-flight credit accounting.
- FSM states:
  - INIT: lasts one cycle. count <= CREDIT_INIT; any i_credit_return in INIT is ignored. Next state is ACTIVE.
  - ACTIVE: count > 0 and o_req_ready = 1.
  - STARVED: count == 0 and o_req_ready = 0.
  - ERROR: o_req_ready = 0 and count frozen. The only exit is reset.
- o_req_ready = (state == ACTIVE). It is a pure function of registered state, with no combinational path from i_req_valid.
- Count update per cycle, with consume = o_issue and ret = i_credit_return:
  - consume & !ret: count decrements by 1. Use the low 2 bits via the decrement ROM sub-module; borrow out clears bit 2. The 4 to 3 transition is {1,00} to {0,11}.
  - !consume & ret: count increments by 1. If count == CREDIT_INIT already, go to ERROR, set o_err_overflow, and leave count unchanged.
  - consume & ret: count unchanged; no error even when full.
  - neither: hold.
- Transitions:
  - ACTIVE goes to STARVED when the count reaches 0.
  - STARVED goes to ACTIVE on ret; count becomes 1 and o_req_ready rises the next cycle. The latency from return to ready is 1 cycle.
  - A return in STARVED cannot coincide with a consume, because ready is 0.
  - A return arriving exactly when the last credit is consumed leaves the count unchanged (e.g. 1 stays 1), so the state stays ACTIVE.
- o_starved and o_full are derived from the next-state count and registered, so they are coherent with o_credit_count in the same cycle.
- Width rules:
  - Count is held in 3 bits, never exceeds 4, and never wraps below 0.
  - A decrement at 0 is structurally impossible. If the assertion detects one, it is a design bug, not a runtime error.

Decomposition:
- Shared package common_credit_pkg:
  - State encoding localparams: INIT=2'd0, ACTIVE=2'd1, STARVED=2'd2, ERROR=2'd3.
  - CREDIT_W=3 and CREDIT_MAX=4.
- Sub-module common_rtlrom_decr2:
  - 2-bit case-table ROM with ports d[1:0], q[1:0], b (borrow).
  - Mapping: 0 gives {1,3}, 1 gives 0, 2 gives 1, 3 gives 2.
  - It is the counterpart of the existing 2-bit increment ROM, which the increment path reuses.

Test Plan:
- Reset then idle: the first cycle after reset is INIT with ready=0. On the next cycle count=4, o_full=1, ready=1.
- Hold i_req_valid=1 with no returns: o_issue is high for exactly 4 cycles. Count goes 3,2,1,0; o_starved=1 and ready=0 from the cycle after the 4th issue.
- Starved, then one i_credit_return pulse: the next cycle count=1 and ready=1. One issue then returns the block to STARVED.
- Count=1 with consume and return in the same cycle: count stays 1 and ACTIVE holds. At count=4, the same combination keeps count=4 with no error.
- Count=4 and i_credit_return alone: o_err_overflow=1 next cycle, state ERROR, ready=0, count stays 4. The error persists through further stimulus and clears only on reset.
- Reset asserted at count=2 mid-stream: all outputs return to reset values, and after INIT the count reloads to CREDIT_INIT (check with CREDIT_INIT=2 as well, giving o_full at 2).

Source files
------------

// File: rtl/common_credit_pkg.sv
// Shared definitions for the credit-consumer counter: state encoding and widths.
package common_credit_pkg;

  localparam int CREDIT_W   = 3;
  localparam int CREDIT_MAX = 4;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_STARVED = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  typedef enum logic [1:0] {
    INIT    = ST_INIT,
    ACTIVE  = ST_ACTIVE,
    STARVED = ST_STARVED,
    ERROR   = ST_ERROR
  } credit_state_e;

endpackage

// File: rtl/common_rtlrom_decr2.sv
// 2-bit decrement ROM: q = d - 1 with borrow out when d wraps from 0 to 3.
module common_rtlrom_decr2 (
  input  logic [1:0] d,
  output logic [1:0] q,
  output logic       b
);

  // Case-table lookup of {borrow, d - 1}.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
    q = 2'd0;
    b = 1'b0;
    case (d)
      2'd0: begin b = 1'b1; q = 2'd3; end
      2'd1: q = 2'd0;
      2'd2: q = 2'd1;
      2'd3: q = 2'd2;
      default: ;
    endcase
  end

endmodule

// File: rtl/common_credit_decr2.sv
// Transmit-side credit counter for a 4-credit link. Issues consume a credit,
// receiver returns restore one; returns beyond the initial credit count are a
// sticky protocol error that only reset clears.
module common_credit_decr2
  import common_credit_pkg::*;
#(
  parameter int CREDIT_INIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  output logic                o_issue,
  input  logic                i_credit_return,
  output logic [CREDIT_W-1:0] o_credit_count,
  output logic                o_starved,
  output logic                o_full,
  output logic                o_err_overflow
);

  localparam logic [CREDIT_W-1:0] INIT_COUNT = CREDIT_W'(CREDIT_INIT);

  credit_state_e       state_q, state_d;
  logic [CREDIT_W-1:0] count_q, count_d;
  logic                starved_q, full_q, err_q, err_d;

  logic [1:0]          dec_low;
  logic                dec_borrow;
  logic [CREDIT_W-1:0] dec_count;

  // Low two bits go through the ROM; a borrow out clears bit 2 (4 -> 3 is {1,00} -> {0,11}).
  common_rtlrom_decr2 u_decr (
    .d (count_q[1:0]),
    .q (dec_low),
    .b (dec_borrow)
  );

  assign dec_count = {count_q[2] & ~dec_borrow, dec_low};

  // Ready depends only on registered state, never on i_req_valid.
  assign o_req_ready    = (state_q == ACTIVE);
  assign o_issue        = i_req_valid & o_req_ready;
  assign o_credit_count = count_q;
  assign o_starved      = starved_q;
  assign o_full         = full_q;
  assign o_err_overflow = err_q;

  // Next-state and next-count logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        // Returns seen during the load cycle are ignored.
        count_d = INIT_COUNT;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        if (o_issue && !i_credit_return) begin
          count_d = dec_count;
          if (dec_count == '0) state_d = STARVED;
        end else if (!o_issue && i_credit_return) begin
          if (count_q == INIT_COUNT) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            count_d = count_q + CREDIT_W'(1);
          end
        end
      end
      STARVED: begin
        // Ready is low here, so a return never coincides with a consume.
        if (i_credit_return) begin
          count_d = count_q + CREDIT_W'(1);
          state_d = ACTIVE;
        end
      end
      ERROR: ;
      default: ;
    endcase
  end

  // State register; flags are computed from the next count so they track o_credit_count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= INIT;
      count_q   <= '0;
      starved_q <= 1'b1;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      starved_q <= (count_d == '0);
      full_q    <= (count_d == INIT_COUNT);
      err_q     <= err_d;
    end
  end

  // A decrement at zero can only come from a logic bug, not from traffic.
  a_no_decr_at_zero : assert property (@(posedge clk) disable iff (reset)
    !(o_issue && !i_credit_return && count_q == '0));

  // Count must stay within the link's credit capacity.
  a_count_in_range : assert property (@(posedge clk) disable iff (reset)
    count_q <= CREDIT_W'(CREDIT_MAX));

  // CREDIT_INIT outside 1..4 is a configuration error.
  a_cfg_range : assert property (@(posedge clk)
    (CREDIT_INIT >= 1) && (CREDIT_INIT <= CREDIT_MAX));

endmodule

// File: tb/tb_common_credit_decr2.sv
// Scoreboard bench for common_credit_decr2: directed vectors push expected
// outputs, a monitor pops and compares them on the falling clock edge.
module tb_common_credit_decr2;

  typedef struct {
    bit         sel;   // 0: CREDIT_INIT=4 instance, 1: CREDIT_INIT=2 instance
    bit         chk;
    string      tag;
    logic       rdy;
    logic       iss;
    logic [2:0] cnt;
    logic       stv;
    logic       full;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b1, rst2 = 1'b1;
  logic valid = 1'b0, ret = 1'b0;

  logic       rdy4, iss4, stv4, full4, err4;
  logic [2:0] cnt4;
  logic       rdy2, iss2, stv2, full2, err2;
  logic [2:0] cnt2;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  common_credit_decr2 #(.CREDIT_INIT(4)) dut4 (
    .clk(clk), .reset(rst4), .i_req_valid(valid), .o_req_ready(rdy4),
    .o_issue(iss4), .i_credit_return(ret), .o_credit_count(cnt4),
    .o_starved(stv4), .o_full(full4), .o_err_overflow(err4)
  );

  common_credit_decr2 #(.CREDIT_INIT(2)) dut2 (
    .clk(clk), .reset(rst2), .i_req_valid(valid), .o_req_ready(rdy2),
    .o_issue(iss2), .i_credit_return(ret), .o_credit_count(cnt2),
    .o_starved(stv2), .o_full(full2), .o_err_overflow(err2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what the
  // selected instance should show during that cycle.
  task automatic step(input bit sel, input logic rst, input logic v, input logic r,
                      input bit chk, input string tag,
                      input logic e_rdy, input logic e_iss, input logic [2:0] e_cnt,
                      input logic e_stv, input logic e_full, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst4  = sel ? 1'b1 : rst;
    rst2  = sel ? rst  : 1'b1;
    valid = v;
    ret   = r;
    e.sel = sel; e.chk = chk; e.tag = tag;
    e.rdy = e_rdy; e.iss = e_iss; e.cnt = e_cnt;
    e.stv = e_stv; e.full = e_full; e.err = e_err;
    sb_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          check({e.tag, ".ready"},   8'(e.sel ? rdy2  : rdy4),  8'(e.rdy));
          check({e.tag, ".issue"},   8'(e.sel ? iss2  : iss4),  8'(e.iss));
          check({e.tag, ".count"},   8'(e.sel ? cnt2  : cnt4),  8'(e.cnt));
          check({e.tag, ".starved"}, 8'(e.sel ? stv2  : stv4),  8'(e.stv));
          check({e.tag, ".full"},    8'(e.sel ? full2 : full4), 8'(e.full));
          check({e.tag, ".err"},     8'(e.sel ? err2  : err4),  8'(e.err));
        end
      end
    end
  end

  initial begin
    int budget;
    //    sel rst v  r  chk tag         rdy iss cnt stv full err
    step(0, 1, 0, 0, 0, "pre",        0,  0,  0,  1,  0,   0);
    step(0, 1, 0, 0, 1, "rst",        0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 1, 1, "init_ret",   0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 0, 1, "loaded",     1,  0,  4,  0,  1,   0);
    step(0, 0, 1, 0, 1, "iss1",       1,  1,  4,  0,  1,   0);
    step(0, 0, 1, 0, 1, "iss2",       1,  1,  3,  0,  0,   0);
    step(0, 0, 1, 0, 1, "iss3",       1,  1,  2,  0,  0,   0);
    step(0, 0, 1, 0, 1, "iss4",       1,  1,  1,  0,  0,   0);
    step(0, 0, 1, 0, 1, "starve_a",   0,  0,  0,  1,  0,   0);
    step(0, 0, 1, 0, 1, "starve_b",   0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 1, 1, "st_ret",     0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 0, 1, "revive",     1,  0,  1,  0,  0,   0);
    step(0, 0, 1, 1, 1, "both_at1",   1,  1,  1,  0,  0,   0);
    step(0, 0, 1, 0, 1, "last_iss",   1,  1,  1,  0,  0,   0);
    step(0, 0, 0, 1, 1, "st_ret2",    0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 1, 1, "inc_1",      1,  0,  1,  0,  0,   0);
    step(0, 0, 0, 1, 1, "inc_2",      1,  0,  2,  0,  0,   0);
    step(0, 0, 0, 1, 1, "inc_3",      1,  0,  3,  0,  0,   0);
    step(0, 0, 1, 1, 1, "both_full",  1,  1,  4,  0,  1,   0);
    step(0, 0, 0, 1, 1, "ovf_ret",    1,  0,  4,  0,  1,   0);
    step(0, 0, 1, 0, 1, "err_a",      0,  0,  4,  0,  1,   1);
    step(0, 0, 1, 1, 1, "err_b",      0,  0,  4,  0,  1,   1);
    step(0, 1, 0, 0, 1, "err_rst",    0,  0,  4,  0,  1,   1);
    step(0, 0, 0, 0, 1, "init2",      0,  0,  0,  1,  0,   0);
    step(0, 0, 1, 0, 1, "reld_iss",   1,  1,  4,  0,  1,   0);
    step(0, 0, 1, 0, 1, "reld_iss2",  1,  1,  3,  0,  0,   0);
    step(0, 1, 0, 0, 1, "mid_rst",    1,  0,  2,  0,  0,   0);
    step(0, 0, 1, 0, 1, "init3",      0,  0,  0,  1,  0,   0);
    step(0, 0, 0, 0, 1, "reload",     1,  0,  4,  0,  1,   0);
    // CREDIT_INIT = 2 instance
    step(1, 1, 0, 0, 1, "c2_rst",     0,  0,  0,  1,  0,   0);
    step(1, 0, 1, 0, 1, "c2_init",    0,  0,  0,  1,  0,   0);
    step(1, 0, 1, 0, 1, "c2_loaded",  1,  1,  2,  0,  1,   0);
    step(1, 0, 0, 0, 1, "c2_one",     1,  0,  1,  0,  0,   0);
    step(1, 0, 0, 1, 1, "c2_inc",     1,  0,  1,  0,  0,   0);
    step(1, 0, 0, 1, 1, "c2_ovf",     1,  0,  2,  0,  1,   0);
    step(1, 0, 0, 0, 1, "c2_err",     0,  0,  2,  0,  1,   1);
    step(1, 1, 0, 0, 1, "c2_errrst",  0,  0,  2,  0,  1,   1);
    step(1, 0, 0, 0, 1, "c2_init2",   0,  0,  0,  1,  0,   0);
    step(1, 0, 1, 0, 1, "c2_reload",  1,  1,  2,  0,  1,   0);
    step(1, 0, 0, 0, 1, "c2_after",   1,  0,  1,  0,  0,   0);

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    n_checks++;
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
